// File: rtl/clock_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_ctrl
// Description : Run-time programmable clock divider with clean start/stop,
//               glitch-free divide-ratio reload and optional counted bursts.
//               Optional feature macro: CLOCK_DIVCTL_BURST_EN (compiles in
//               the BURST state and the burst period counter).
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_ctrl #(
    parameter int WIDTH         = 26,
    parameter int DEFAULT_COUNT = 50_000_000,
    parameter int BURST_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       cfg_count,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   run,
    input  logic                   burst_start,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   clock,
    output logic                   tick,
    output logic                   busy,
    output logic                   burst_done
);

    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_DEFAULT = WIDTH'(DEFAULT_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2,
        ST_BURST    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_clock;
    logic             w_clock_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_pending;
    logic             r_pend;

    logic             w_terminal;
    logic             w_counting;
    logic             w_to_idle;
    logic             w_accept;
    logic [WIDTH-1:0] w_cfg_eff;

    // active_count is never 0, so the subtraction cannot wrap
    assign w_terminal = (r_cnt == (r_active - c_ONE));
    assign w_counting = (r_state != ST_IDLE);
    assign w_to_idle  = w_counting && (w_state_nxt == ST_IDLE);
    assign w_accept   = cfg_valid && cfg_ready;
    // A requested half-period of 0 behaves as 1
    assign w_cfg_eff  = (cfg_count == '0) ? c_ONE : cfg_count;

    assign cfg_ready  = ~r_pend;
    assign clock      = r_clock;
    assign tick       = r_tick;
    assign busy       = (r_state != ST_IDLE);

`ifdef CLOCK_DIVCTL_BURST_EN
    localparam logic [BURST_WIDTH-1:0] c_BONE = BURST_WIDTH'(1);

    logic [BURST_WIDTH-1:0] r_bcnt;
    logic [BURST_WIDTH-1:0] w_bcnt_nxt;
    logic                   r_burst_done;
    logic                   w_burst_done_nxt;

    assign burst_done = r_burst_done;

    // Burst period counter and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bcnt       <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_bcnt       <= w_bcnt_nxt;
            r_burst_done <= w_burst_done_nxt;
        end
    end
`else
    logic w_unused_burst;

    assign w_unused_burst = ^{burst_start, burst_len};
    assign burst_done     = 1'b0;
`endif

    // Next-state, half-period counter and output-clock decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_terminal ? '0 : (r_cnt + c_ONE);
        w_clock_nxt = w_terminal ? ~r_clock : r_clock;
        w_tick_nxt  = 1'b0;
`ifdef CLOCK_DIVCTL_BURST_EN
        w_bcnt_nxt       = r_bcnt;
        w_burst_done_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt   = '0;
                w_clock_nxt = 1'b0;
                if (run) begin
                    w_state_nxt = ST_RUN;
`ifdef CLOCK_DIVCTL_BURST_EN
                end else if (burst_start && (burst_len != '0)) begin
                    w_state_nxt = ST_BURST;
                    w_bcnt_nxt  = burst_len;
`endif
                end
            end
            ST_RUN: begin
                if (!run && !r_clock) begin
                    // Already low: stop at once without finishing the phase
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_clock_nxt = 1'b0;
                end else if (!run) begin
                    // High phase must complete; if it ends now, we are done
                    w_state_nxt = w_terminal ? ST_IDLE : ST_STOPPING;
                end else begin
                    w_tick_nxt = w_terminal && !r_clock;
                end
            end
            ST_STOPPING: begin
                // clock is high here; terminal takes it low and ends the stop
                if (w_terminal) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef CLOCK_DIVCTL_BURST_EN
            ST_BURST: begin
                w_tick_nxt = w_terminal && !r_clock;
                if (w_terminal && r_clock) begin
                    w_bcnt_nxt = r_bcnt - c_BONE;
                    if (r_bcnt == c_BONE) begin
                        w_state_nxt      = ST_IDLE;
                        w_burst_done_nxt = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_clock_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and registered output flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_clock <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clock <= w_clock_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Ratio reload: direct when idle, otherwise deferred to a half-period
    // boundary (or to the return to IDLE) so no half-period is ever altered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active  <= c_DEFAULT;
            r_pending <= '0;
            r_pend    <= 1'b0;
        end else begin
            if (r_pend && ((w_counting && w_terminal) || w_to_idle)) begin
                r_active <= r_pending;
                r_pend   <= 1'b0;
            end
            if (w_accept) begin
                if (!w_counting || w_to_idle) begin
                    r_active <= w_cfg_eff;
                end else begin
                    r_pending <= w_cfg_eff;
                    r_pend    <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
